regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, register index width; NREG = 2**ADDR_W registers (default 8).
REQ-003 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port we, input, 1, write enable.
REQ-006 SHALL have port waddr, input, ADDR_W, write index.
REQ-007 SHALL have port wdata, input, DATA_W, write data.
REQ-008 SHALL have port re, input, 1, read request for both read ports.
REQ-009 SHALL have ports raddr1 and raddr2, input, ADDR_W each, read indices.
REQ-010 SHALL have ports rdata1 and rdata2, output, DATA_W each, registered read data.
REQ-011 SHALL have port rvalid, output, 1, read data valid, a one-cycle pulse.
REQ-012 SHALL have port clr_req, input, 1, request to clear all registers.
REQ-013 SHALL have port clr_busy, output, 1, high while clear is in progress.
REQ-014 SHALL have port clr_done, output, 1, one-cycle pulse when clear completes.

Function
REQ-015 SHALL write wdata to reg[waddr] at the clock edge where we=1 and state is IDLE.
REQ-016 SHALL, at the edge where re=1 and state is IDLE, load rdata1=reg[raddr1] and rdata2=reg[raddr2], and set rvalid=1 for exactly the following cycle; read latency is 1 cycle.
REQ-017 SHALL hold rdata1/rdata2 and drive rvalid=0 when re=0.
REQ-018 SHALL accept a write and a read in the same cycle; a read of a different index is unaffected by the write.
REQ-019 SHALL have an FSM with states IDLE, CLEAR and DONE.
REQ-020 SHALL move IDLE->CLEAR on clr_req=1, with the clear counter set to 0.
REQ-021 SHALL, in CLEAR, write zero to reg[counter] and increment the counter each cycle; at counter=NREG-1 it SHALL move to DONE, so clearing takes NREG cycles.
REQ-022 SHALL, in DONE, assert clr_done for one cycle, then move to IDLE.
REQ-023 SHALL drive clr_busy=1 in CLEAR and DONE, and 0 in IDLE.
REQ-024 SHALL ignore we, re and clr_req while clr_busy=1; rvalid stays 0.
REQ-025 SHALL give clr_req priority when clr_req, we and re are all high in IDLE: the write and read are dropped and the FSM enters CLEAR.
REQ-026 SHALL treat the counter as ADDR_W bits wide; it never wraps beyond NREG-1 within one clear.

Reset
REQ-027 SHALL, while rst=0, force all NREG registers to 0, rdata1/rdata2 to 0, rvalid, clr_busy and clr_done to 0, FSM to IDLE and counter to 0, regardless of clk.
REQ-028 SHALL abort a clear in progress when reset is asserted mid-CLEAR; after release the FSM is in IDLE and all registers are 0.

Configuration
REQ-029 SHALL support macro REGFILE_BYPASS_EN.
REQ-030 With REGFILE_BYPASS_EN defined, a read whose index equals waddr while the write is accepted in the same cycle SHALL return wdata (write-through forwarding), per port independently.
REQ-031 Without REGFILE_BYPASS_EN, that read SHALL return the register value before the write.

Structure
REQ-032 SHALL take the FSM state encoding (IDLE, CLEAR, DONE) and the default DATA_W/ADDR_W constants from shared package regfile_pkg.
REQ-033 SHALL place the clear FSM and counter in sub-module regfile_clr_fsm; the storage array and read/write logic stay in regfile_param.

Verification
REQ-034 Bench SHALL drive a write of reg[3]=0xDEADBEEF, then re with raddr1=3 and raddr2=0, and check rdata1=0xDEADBEEF, rdata2=0 and rvalid=1 exactly one cycle later.
REQ-035 Bench SHALL, in the same cycle, write reg[5]=0x12345678 and read raddr1=5, then check rdata1=0x12345678 with REGFILE_BYPASS_EN defined and the old value (0) without it.
REQ-036 Bench SHALL fill all 8 registers with nonzero values, pulse clr_req, and check clr_busy=1 for 9 cycles (8 CLEAR + 1 DONE), a single clr_done pulse, and all registers reading 0 afterwards.
REQ-037 Bench SHALL assert we=1 (waddr=2, wdata=0xFF) and re=1 during CLEAR, and check that reg[2] is 0 after the clear and that rvalid stays 0 throughout.
REQ-038 Bench SHALL assert rst=0 asynchronously, mid-cycle, during CLEAR at counter=4, and check that all outputs are 0 immediately and the FSM is in IDLE after release.
REQ-039 Bench SHALL rerun the first and third scenarios with DATA_W=16 and ADDR_W=4, and check 16 clear cycles plus 1 DONE cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and clear-FSM state encoding for the parameterised register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks an ADDR_W-bit counter over every register index,
// then spends one DONE cycle pulsing clr_done before returning to IDLE.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_wr,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              idle
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;

  // State, counter and registered busy/done flags; reset aborts any clear in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state    <= ST_CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (cnt == LAST_IDX) begin
            state    <= ST_DONE;
            cnt      <= '0;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          cnt      <= '0;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  // Decoded strobes for the storage array, derived directly from the state register.
  always_comb begin
    clr_wr   = (state == ST_CLEAR);
    idle     = (state == ST_IDLE);
    clr_addr = cnt;
  end

endmodule

// File: rtl/regfile_param.sv
// Parameterised 1-write / 2-read register file with registered reads and a
// sequenced clear. Define REGFILE_BYPASS_EN to forward same-cycle write data
// to a read of the same index; otherwise such a read returns the old value.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NREG];

  logic              clr_wr;
  logic [ADDR_W-1:0] clr_addr;
  logic              idle;
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] rd_val1;
  logic [DATA_W-1:0] rd_val2;

  regfile_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_wr   (clr_wr),
    .clr_addr (clr_addr),
    .idle     (idle)
  );

  // Host accesses only in IDLE; a clear request in the same cycle wins over both.
  always_comb begin
    wr_ok = idle & we & ~clr_req;
    rd_ok = idle & re & ~clr_req;
  end

  // Read-port data selection, with optional write-through forwarding per port.
  always_comb begin
    rd_val1 = mem[raddr1];
    rd_val2 = mem[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (waddr == raddr1)) rd_val1 = wdata;
    if (wr_ok && (waddr == raddr2)) rd_val2 = wdata;
`endif
  end

  // Storage array: the clear sequencer and host writes are mutually exclusive by state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '{default: '0};
    end else if (clr_wr) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read data held between reads, with a one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata1 <= '0;
      rdata2 <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_ok;
      if (rd_ok) begin
        rdata1 <= rd_val1;
        rdata2 <= rd_val2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a default instance (32x8) and a 16x16
// instance share clock and reset; expected read data is queued at stimulus time.
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_we, a_re, a_clr;
  logic [2:0]  a_waddr, a_raddr1, a_raddr2;
  logic [31:0] a_wdata, a_rdata1, a_rdata2;
  logic        a_rvalid, a_busy, a_done;

  logic        b_we, b_re, b_clr;
  logic [3:0]  b_waddr, b_raddr1, b_raddr2;
  logic [15:0] b_wdata, b_rdata1, b_rdata2;
  logic        b_rvalid, b_busy, b_done;

  regfile_param #(.DATA_W(32), .ADDR_W(3)) dut_a (
    .clk(clk), .rst(rst), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .re(a_re), .raddr1(a_raddr1), .raddr2(a_raddr2),
    .rdata1(a_rdata1), .rdata2(a_rdata2), .rvalid(a_rvalid),
    .clr_req(a_clr), .clr_busy(a_busy), .clr_done(a_done)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(4)) dut_b (
    .clk(clk), .rst(rst), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .re(b_re), .raddr1(b_raddr1), .raddr2(b_raddr2),
    .rdata1(b_rdata1), .rdata2(b_rdata2), .rvalid(b_rvalid),
    .clr_req(b_clr), .clr_busy(b_busy), .clr_done(b_done)
  );

  bit          sel;
  logic [31:0] o_rd1, o_rd2;
  logic        o_rvalid, o_busy, o_done;

  always_comb begin
    if (sel) begin
      o_rd1 = {16'h0, b_rdata1}; o_rd2 = {16'h0, b_rdata2};
      o_rvalid = b_rvalid; o_busy = b_busy; o_done = b_done;
    end else begin
      o_rd1 = a_rdata1; o_rd2 = a_rdata2;
      o_rvalid = a_rvalid; o_busy = a_busy; o_done = a_done;
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] d1;
    logic [31:0] d2;
  } rd_exp_t;

  rd_exp_t     sb[$];
  logic [31:0] mdl [2][16];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] dmask();
    return sel ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  task automatic drive(input logic we_i, input int wa, input logic [31:0] wd,
                       input logic re_i, input int r1, input int r2, input logic clr_i);
    if (sel) begin
      b_we = we_i; b_waddr = wa[3:0]; b_wdata = wd[15:0];
      b_re = re_i; b_raddr1 = r1[3:0]; b_raddr2 = r2[3:0]; b_clr = clr_i;
    end else begin
      a_we = we_i; a_waddr = wa[2:0]; a_wdata = wd;
      a_re = re_i; a_raddr1 = r1[2:0]; a_raddr2 = r2[2:0]; a_clr = clr_i;
    end
  endtask

  task automatic idle_in();
    drive(1'b0, 0, 32'h0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic zero_model();
    for (int i = 0; i < 16; i++) mdl[sel][i] = 32'h0;
  endtask

  task automatic wr(input int wa, input logic [31:0] wd);
    @(negedge clk);
    drive(1'b1, wa, wd, 1'b0, 0, 0, 1'b0);
    @(posedge clk); #1;
    idle_in();
    mdl[sel][wa] = wd & dmask();
  endtask

  task automatic pop_check();
    rd_exp_t e;
    check("rvalid", {31'h0, o_rvalid}, 32'h1);
    if (sb.size() == 0) begin
      check("sb_empty", 32'h0, 32'h1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "/rdata1"}, o_rd1, e.d1);
      check({e.tag, "/rdata2"}, o_rd2, e.d2);
    end
  endtask

  task automatic rd(input string tag, input int r1, input int r2);
    rd_exp_t e;
    @(negedge clk);
    drive(1'b0, 0, 32'h0, 1'b1, r1, r2, 1'b0);
    e.tag = tag; e.d1 = mdl[sel][r1]; e.d2 = mdl[sel][r2];
    sb.push_back(e);
    @(posedge clk); #1;
    idle_in();
    pop_check();
  endtask

  task automatic fill(input int nreg);
    for (int i = 0; i < nreg; i++) wr(i, 32'hC0DE_0000 + i + 1);
  endtask

  // Pulse clr_req (optionally with competing we/re, kept up while busy) and
  // count busy cycles, done pulses and any rvalid over the whole clear window.
  task automatic clear_run(input string tag, input int nreg, input bit noise);
    int busy_n = 0;
    int done_n = 0;
    int rv_n   = 0;
    @(negedge clk);
    drive(noise, 2, 32'hFF, noise, 2, 2, 1'b1);
    for (int i = 0; i < nreg + 4; i++) begin
      @(posedge clk); #1;
      if (o_busy) busy_n++;
      if (o_done) done_n++;
      if (o_rvalid) rv_n++;
      @(negedge clk);
      if (noise && i < nreg) drive(1'b1, 2, 32'hFF, 1'b1, 2, 2, 1'b1);
      else idle_in();
    end
    check({tag, "/busy_cycles"}, busy_n, nreg + 1);
    check({tag, "/done_pulses"}, done_n, 1);
    check({tag, "/rvalid_during_clear"}, rv_n, 0);
    zero_model();
    for (int r = 0; r < nreg; r += 2) rd({tag, "/post_clear"}, r, r + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_exp_t e;
    sel = 1'b0;
    rst = 1'b0;
    a_we = 0; a_re = 0; a_clr = 0; a_waddr = '0; a_raddr1 = '0; a_raddr2 = '0; a_wdata = '0;
    b_we = 0; b_re = 0; b_clr = 0; b_waddr = '0; b_raddr1 = '0; b_raddr2 = '0; b_wdata = '0;
    for (int s = 0; s < 2; s++) for (int i = 0; i < 16; i++) mdl[s][i] = 32'h0;

    // Reset state
    #12;
    check("reset/rdata1", o_rd1, 32'h0);
    check("reset/rdata2", o_rd2, 32'h0);
    check("reset/rvalid", {31'h0, o_rvalid}, 32'h0);
    check("reset/clr_busy", {31'h0, o_busy}, 32'h0);
    check("reset/clr_done", {31'h0, o_done}, 32'h0);
    check("reset/b_clr_busy", {31'h0, b_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Write then read, one-cycle latency
    wr(3, 32'hDEAD_BEEF);
    rd("rd3_0", 3, 0);
    @(posedge clk); #1;
    check("rvalid_drop", {31'h0, o_rvalid}, 32'h0);
    check("rdata1_hold", o_rd1, 32'hDEAD_BEEF);

    // Same-cycle write and read of the same index (port 1) and another index (port 2)
    @(negedge clk);
    drive(1'b1, 5, 32'h1234_5678, 1'b1, 5, 3, 1'b0);
    e.tag = "same_cycle";
`ifdef REGFILE_BYPASS_EN
    e.d1 = 32'h1234_5678;
`else
    e.d1 = mdl[0][5];
`endif
    e.d2 = mdl[0][3];
    sb.push_back(e);
    @(posedge clk); #1;
    idle_in();
    mdl[0][5] = 32'h1234_5678;
    pop_check();
    rd("rd5_after", 5, 3);

    // Full clear with competing accesses during and at the request cycle
    fill(8);
    rd("filled", 2, 7);
    clear_run("clr_a", 8, 1'b1);

    // Asynchronous reset in the middle of a clear (counter at 4)
    fill(8);
    rd("pre_rst", 3, 5);
    @(negedge clk);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 0, 1'b1);
    @(posedge clk); #1;
    idle_in();
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("pre_rst/busy", {31'h0, o_busy}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst/rdata1", o_rd1, 32'h0);
    check("mid_rst/rdata2", o_rd2, 32'h0);
    check("mid_rst/rvalid", {31'h0, o_rvalid}, 32'h0);
    check("mid_rst/clr_busy", {31'h0, o_busy}, 32'h0);
    check("mid_rst/clr_done", {31'h0, o_done}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    zero_model();
    @(posedge clk); #1;
    check("post_rst/clr_busy", {31'h0, o_busy}, 32'h0);
    for (int r = 0; r < 8; r += 2) rd("post_rst", r, r + 1);
    wr(6, 32'hA5A5_5A5A);
    rd("post_rst_wr", 6, 0);

    // Wide configuration: 16-bit data, 16 registers
    sel = 1'b1;
    wr(3, 32'h0000_BEEF);
    rd("b_rd3_0", 3, 0);
    fill(16);
    rd("b_filled", 9, 15);
    clear_run("clr_b", 16, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
